// File: rtl/camera_i2c_reg_sequencer.sv
// Camera register writer that sequences a Wishbone op controller driving an OpenCores I2C master.
// Define CAM_I2C_READBACK_EN to read every written register back and compare it with the data.
module camera_i2c_reg_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
    parameter int unsigned WB_TIMEOUT = 1024,
    parameter int unsigned POLL_LIMIT = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_reg_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_code_o,
    output logic [2:0]  wb_ctrl_reg_o,
    output logic        wb_ctrl_trig_wr_o,
    output logic        wb_ctrl_trig_rd_o,
    output logic [7:0]  wb_ctrl_wr_data_o,
    input  logic [7:0]  wb_ctrl_rd_data_i,
    input  logic        wb_ctrl_done_i
);
    localparam int unsigned WaitW = $clog2(WB_TIMEOUT + 1);
    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] RegPrerLo = 3'd0;
    localparam logic [2:0] RegPrerHi = 3'd1;
    localparam logic [2:0] RegCtr    = 3'd2;
    localparam logic [2:0] RegTxRx   = 3'd3;
    localparam logic [2:0] RegCrSr   = 3'd4;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrNack    = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

`ifdef CAM_I2C_READBACK_EN
    localparam logic [3:0] FinalByte = 4'd8;
    localparam logic [1:0] ErrReadback = 2'd3;
`else
    localparam logic [3:0] FinalByte = 4'd3;
`endif

    typedef enum logic [3:0] {
        StInitPrerLo, StInitPrerHi, StInitCtr, StIdle, StTxLoad, StCrLoad, StSrPoll, StSrCheck,
        StStopCr, StStopPoll, StStopCheck, StFinish, StWbWait
`ifdef CAM_I2C_READBACK_EN
        , StRxRead, StRxCheck
`endif
    } state_e;

    state_e             state_q, state_d, ret_q, ret_d, issue_ret;
    logic [3:0]         byte_q, byte_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         cdata_q, cdata_d;
    logic               tip_q, tip_d, rxack_q, rxack_d;
    logic               reinit_q, reinit_d;
    logic               cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]         err_q, err_d, fin_err;
    logic [2:0]         reg_q, reg_d, issue_reg;
    logic [7:0]         wdata_q, wdata_d, issue_data;
    logic               trig_wr_q, trig_wr_d, trig_rd_q, trig_rd_d;
    logic               issue_wr, issue_rd, finish, timeout, init_op, ack_chk;
    logic [7:0]         txr_byte, cr_byte;
`ifdef CAM_I2C_READBACK_EN
    logic               rx_mis_q, rx_mis_d;
`endif

    // Bytes 4..7 re-address the register with a repeated START; byte 8 is the single-byte read.
    always_comb begin
        case (byte_q)
            4'd0, 4'd4: txr_byte = {SLAVE_ADDR, 1'b0};
            4'd1, 4'd5: txr_byte = addr_q[15:8];
            4'd2, 4'd6: txr_byte = addr_q[7:0];
            4'd3:       txr_byte = cdata_q;
            default:    txr_byte = {SLAVE_ADDR, 1'b1};
        endcase
        case (byte_q)
            4'd0, 4'd4, 4'd7: cr_byte = 8'h90;
            4'd3:             cr_byte = 8'h50;
            4'd8:             cr_byte = 8'h68;
            default:          cr_byte = 8'h10;
        endcase
    end

`ifdef CAM_I2C_READBACK_EN
    assign ack_chk = (byte_q != 4'd8);
`else
    assign ack_chk = 1'b1;
`endif

    assign init_op = (ret_q == StInitPrerHi) || (ret_q == StInitCtr) || (ret_q == StIdle);

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        byte_d     = byte_q;
        wait_cnt_d = wait_cnt_q;
        poll_cnt_d = poll_cnt_q;
        addr_d     = addr_q;
        cdata_d    = cdata_q;
        tip_d      = tip_q;
        rxack_d    = rxack_q;
        reinit_d   = reinit_q;
        err_d      = err_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        trig_wr_d  = 1'b0;
        trig_rd_d  = 1'b0;
        done_d     = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        issue_reg  = RegCrSr;
        issue_data = 8'h00;
        issue_ret  = StIdle;
        finish     = 1'b0;
        fin_err    = ErrOk;
        timeout    = 1'b0;
`ifdef CAM_I2C_READBACK_EN
        rx_mis_d   = rx_mis_q;
`endif

        case (state_q)
            StInitPrerLo: begin
                reinit_d = 1'b0;
                {issue_wr, issue_reg, issue_data, issue_ret} =
                    {1'b1, RegPrerLo, PRESCALE[7:0], StInitPrerHi};
            end
            StInitPrerHi: begin
                {issue_wr, issue_reg, issue_data, issue_ret} =
                    {1'b1, RegPrerHi, PRESCALE[15:8], StInitCtr};
            end
            StInitCtr: begin
                {issue_wr, issue_reg, issue_data, issue_ret} = {1'b1, RegCtr, 8'h80, StIdle};
            end
            StIdle: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d     = cmd_reg_addr_i;
                    cdata_d    = cmd_data_i;
                    byte_d     = 4'd0;
                    err_d      = ErrOk;
                    poll_cnt_d = '0;
                    state_d    = StTxLoad;
                end
            end
            StTxLoad: begin
                poll_cnt_d = '0;
                {issue_wr, issue_reg, issue_data, issue_ret} = {1'b1, RegTxRx, txr_byte, StCrLoad};
            end
            StCrLoad: begin
                {issue_wr, issue_reg, issue_data, issue_ret} = {1'b1, RegCrSr, cr_byte, StSrPoll};
            end
            StSrPoll: begin
                if (poll_cnt_q != '1) poll_cnt_d = poll_cnt_q + 1'b1;
                {issue_rd, issue_reg, issue_ret} = {1'b1, RegCrSr, StSrCheck};
            end
            StSrCheck: begin
                if (tip_q) begin
                    if (poll_cnt_q >= PollW'(POLL_LIMIT)) timeout = 1'b1;
                    else                                   state_d = StSrPoll;
                end else if (rxack_q && ack_chk) begin
                    state_d = StStopCr;
                end else if (byte_q == FinalByte) begin
`ifdef CAM_I2C_READBACK_EN
                    state_d = StRxRead;
`else
                    finish  = 1'b1;
`endif
                end else begin
                    byte_d     = byte_q + 4'd1;
                    poll_cnt_d = '0;
                    // The read byte has no TXR payload, only the RD|NACK|STO command.
                    state_d    = (byte_q == 4'd7) ? StCrLoad : StTxLoad;
                end
            end
            StStopCr: begin
                poll_cnt_d = '0;
                {issue_wr, issue_reg, issue_data, issue_ret} = {1'b1, RegCrSr, 8'h40, StStopPoll};
            end
            StStopPoll: begin
                if (poll_cnt_q != '1) poll_cnt_d = poll_cnt_q + 1'b1;
                {issue_rd, issue_reg, issue_ret} = {1'b1, RegCrSr, StStopCheck};
            end
            StStopCheck: begin
                if (tip_q) begin
                    if (poll_cnt_q >= PollW'(POLL_LIMIT)) timeout = 1'b1;
                    else                                   state_d = StStopPoll;
                end else begin
                    finish  = 1'b1;
                    fin_err = ErrNack;
                end
            end
            StFinish: begin
                state_d = reinit_q ? StInitPrerLo : StIdle;
            end
            StWbWait: begin
                if (wb_ctrl_done_i) begin
                    tip_d   = wb_ctrl_rd_data_i[1];
                    rxack_d = wb_ctrl_rd_data_i[7];
`ifdef CAM_I2C_READBACK_EN
                    rx_mis_d = (wb_ctrl_rd_data_i != cdata_q);
`endif
                    state_d = ret_q;
                end else if (wait_cnt_q >= WaitW'(WB_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
`ifdef CAM_I2C_READBACK_EN
            StRxRead: begin
                {issue_rd, issue_reg, issue_ret} = {1'b1, RegTxRx, StRxCheck};
            end
            StRxCheck: begin
                finish  = 1'b1;
                fin_err = rx_mis_q ? ErrReadback : ErrOk;
            end
`endif
            default: state_d = StInitPrerLo;
        endcase

        if (issue_wr || issue_rd) begin
            trig_wr_d  = issue_wr;
            trig_rd_d  = issue_rd;
            reg_d      = issue_reg;
            wdata_d    = issue_data;
            ret_d      = issue_ret;
            wait_cnt_d = '0;
            state_d    = StWbWait;
        end

        // A stalled init op has no command to report against, so it just restarts init.
        if (timeout) begin
            if (init_op) begin
                state_d = StInitPrerLo;
            end else begin
                finish   = 1'b1;
                fin_err  = ErrTimeout;
                reinit_d = 1'b1;
            end
        end

        if (finish) begin
            err_d   = fin_err;
            done_d  = 1'b1;
            state_d = StFinish;
        end

        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInitPrerLo;
            ret_q       <= StIdle;
            byte_q      <= 4'd0;
            wait_cnt_q  <= '0;
            poll_cnt_q  <= '0;
            addr_q      <= 16'h0000;
            cdata_q     <= 8'h00;
            tip_q       <= 1'b0;
            rxack_q     <= 1'b0;
            reinit_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ErrOk;
            reg_q       <= 3'd0;
            wdata_q     <= 8'h00;
            trig_wr_q   <= 1'b0;
            trig_rd_q   <= 1'b0;
`ifdef CAM_I2C_READBACK_EN
            rx_mis_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            byte_q      <= byte_d;
            wait_cnt_q  <= wait_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            addr_q      <= addr_d;
            cdata_q     <= cdata_d;
            tip_q       <= tip_d;
            rxack_q     <= rxack_d;
            reinit_q    <= reinit_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            trig_wr_q   <= trig_wr_d;
            trig_rd_q   <= trig_rd_d;
`ifdef CAM_I2C_READBACK_EN
            rx_mis_q    <= rx_mis_d;
`endif
        end
    end

    assign cmd_ready_o       = cmd_ready_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_code_o        = err_q;
    assign wb_ctrl_reg_o     = reg_q;
    assign wb_ctrl_wr_data_o = wdata_q;
    assign wb_ctrl_trig_wr_o = trig_wr_q;
    assign wb_ctrl_trig_rd_o = trig_rd_q;

endmodule

// File: tb/tb_camera_i2c_reg_sequencer.sv
// Bench for camera_i2c_reg_sequencer: a Wishbone controller stub checks every op against a
// scoreboard of expected ops; command vectors come from a table plus hand-built corner cases.
module tb_camera_i2c_reg_sequencer;
    localparam int unsigned TO  = 40;
    localparam int unsigned PL  = 6;
    localparam int          NoNack = 99;
`ifdef CAM_I2C_READBACK_EN
    localparam bit         Rb = 1'b1;
`else
    localparam bit         Rb = 1'b0;
`endif
    localparam int         NumBytes = Rb ? 8 : 4;
    localparam logic [1:0] RbErr    = Rb ? 2'd3 : 2'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_data = 8'h0;
    logic        busy, done;
    logic [1:0]  err_code;
    logic [2:0]  wb_reg;
    logic        trig_wr, trig_rd;
    logic [7:0]  wb_wdata;
    logic [7:0]  wb_rdata = 8'h0;
    logic        wb_done = 1'b0;

    camera_i2c_reg_sequencer #(
        .PRESCALE  (16'd99),
        .SLAVE_ADDR(7'h3C),
        .WB_TIMEOUT(TO),
        .POLL_LIMIT(PL)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_reg_addr_i   (cmd_addr),
        .cmd_data_i       (cmd_data),
        .busy_o           (busy),
        .done_o           (done),
        .err_code_o       (err_code),
        .wb_ctrl_reg_o    (wb_reg),
        .wb_ctrl_trig_wr_o(trig_wr),
        .wb_ctrl_trig_rd_o(trig_rd),
        .wb_ctrl_wr_data_o(wb_wdata),
        .wb_ctrl_rd_data_i(wb_rdata),
        .wb_ctrl_done_i   (wb_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd;
        logic [2:0] rg;
        logic [7:0] dat;
    } op_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          nack;
        int          tip;
        logic [7:0]  rxr;
        logic [1:0]  exp_err;
    } vec_t;

    op_t        exp_q[$];
    logic [7:0] sr_resp[$];
    int         checks = 0;
    int         errors = 0;
    int         op_cnt = 0;
    int         withhold_at = -1;
    logic [7:0] rxr_val = 8'h00;
    logic [7:0] rd_val = 8'h00;
    bit         pend = 1'b0;
    int         dly = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Controller stub: answers each op two cycles after its trigger unless told to withhold it.
    always @(negedge clk) begin
        op_t got;
        op_t exp;
        wb_done = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (trig_wr || trig_rd) begin
            got = {trig_rd, wb_reg, trig_rd ? 8'h00 : wb_wdata};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_op: got 0x%0h, expected no op", got);
            end else begin
                exp = exp_q.pop_front();
                check("wb_op", 32'(got), 32'(exp));
            end
            if (trig_rd) begin
                if (wb_reg == 3'd4) rd_val = (sr_resp.size() != 0) ? sr_resp.pop_front() : 8'h00;
                else                rd_val = rxr_val;
            end
            if (withhold_at != op_cnt) begin
                pend = 1'b1;
                dly  = 1;
            end
            op_cnt++;
        end else if (pend) begin
            if (dly == 0) begin
                wb_done  = 1'b1;
                wb_rdata = rd_val;
                pend     = 1'b0;
            end else begin
                dly--;
            end
        end
    end

    task automatic exp_wr(input logic [2:0] r, input logic [7:0] d);
        exp_q.push_back({1'b0, r, d});
    endtask

    task automatic exp_rd(input logic [2:0] r, input logic [7:0] resp);
        exp_q.push_back({1'b1, r, 8'h00});
        if (r == 3'd4) sr_resp.push_back(resp);
    endtask

    task automatic push_init_ops();
        exp_wr(3'd0, 8'h63);
        exp_wr(3'd1, 8'h00);
        exp_wr(3'd2, 8'h80);
    endtask

    task automatic push_cmd_ops(input logic [15:0] a, input logic [7:0] d, input int nack,
                                input int tip);
        logic [7:0] txr[8];
        logic [7:0] cr[8];
        txr = '{8'h78, a[15:8], a[7:0], d, 8'h78, a[15:8], a[7:0], 8'h79};
        cr  = '{8'h90, 8'h10, 8'h10, 8'h50, 8'h90, 8'h10, 8'h10, 8'h90};
        for (int b = 0; b < NumBytes; b++) begin
            exp_wr(3'd3, txr[b]);
            exp_wr(3'd4, cr[b]);
            if (b == 0) for (int t = 0; t < tip; t++) exp_rd(3'd4, 8'h02);
            if (b == nack) begin
                exp_rd(3'd4, 8'h80);
                exp_wr(3'd4, 8'h40);
                exp_rd(3'd4, 8'h00);
                return;
            end
            exp_rd(3'd4, 8'h00);
        end
        if (Rb) begin
            exp_wr(3'd4, 8'h68);
            exp_rd(3'd4, 8'h00);
            exp_rd(3'd3, 8'h00);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_wait: got cmd_ready=0 after %0d cycles, expected 1", nm, n);
        end
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [7:0] d);
        wait_ready("send");
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [1:0] exp_err, input logic ready_after);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_wait: got done=0 after %0d cycles, expected a pulse", nm, n);
        end else begin
            check({nm, "_err"}, 32'(err_code), 32'(exp_err));
            check({nm, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            check({nm, "_ready_after"}, 32'(cmd_ready), 32'(ready_after));
            check({nm, "_pulse_width"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        int   dones;

        vecs[0] = '{16'h3008, 8'h82, NoNack, 0, 8'h82, 2'd0};
        vecs[1] = '{16'h3008, 8'h82, 1,      0, 8'h82, 2'd1};
        vecs[2] = '{16'h1234, 8'hA5, 0,      0, 8'hA5, 2'd1};
        vecs[3] = '{16'h0000, 8'h00, NoNack, 2, 8'h00, 2'd0};
        vecs[4] = '{16'hFFFF, 8'hFF, 3,      0, 8'hFF, 2'd1};
        vecs[5] = '{16'h3008, 8'h82, NoNack, 0, 8'h81, RbErr};
        vecs[6] = '{16'hABCD, 8'h5A, NoNack, 1, 8'h5A, 2'd0};

        // Reset: every output low, then the three init writes, then ready.
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({cmd_ready, busy, done, err_code, wb_reg, trig_wr, trig_rd,
                                    wb_wdata}), 32'd0);
        push_init_ops();
        rst_n = 1'b1;
        wait_ready("init");
        check("init_ops_drained", 32'(exp_q.size()), 32'd0);
        check("init_busy_low", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            rxr_val = vecs[i].rxr;
            push_cmd_ops(vecs[i].addr, vecs[i].data, vecs[i].nack, vecs[i].tip);
            send_cmd(vecs[i].addr, vecs[i].data);
            wait_done($sformatf("vec%0d", i), vecs[i].exp_err, 1'b1);
            check($sformatf("vec%0d_ops_drained", i), 32'(exp_q.size()), 32'd0);
        end

        // A request while busy is neither accepted nor queued.
        rxr_val = 8'h22;
        push_cmd_ops(16'h1111, 8'h22, NoNack, 0);
        send_cmd(16'h1111, 8'h22);
        cmd_valid = 1'b1;
        cmd_addr  = 16'hBEEF;
        cmd_data  = 8'hEE;
        @(negedge clk);
        check("busy_blocks_ready", 32'({cmd_ready, busy}), 32'b01);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done("busy_ignore", 2'd0, 1'b1);
        repeat (30) @(negedge clk);
        check("busy_ignore_no_extra", 32'(exp_q.size()), 32'd0);

        // TIP never clears: the poll limit ends the command as a timeout and re-runs init.
        exp_wr(3'd3, 8'h78);
        exp_wr(3'd4, 8'h90);
        for (int p = 0; p < PL; p++) exp_rd(3'd4, 8'h02);
        push_init_ops();
        send_cmd(16'h3008, 8'h82);
        wait_done("poll_limit", 2'd2, 1'b0);
        wait_ready("poll_limit");
        check("poll_limit_ops_drained", 32'(exp_q.size()), 32'd0);

        // Second op of a command never completes.
        withhold_at = op_cnt + 1;
        exp_wr(3'd3, 8'h78);
        exp_wr(3'd4, 8'h90);
        push_init_ops();
        send_cmd(16'h3008, 8'h82);
        n = 0;
        while (!(trig_wr && wb_reg == 3'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < 3 * TO) begin
            @(negedge clk);
            n++;
        end
        check("wb_timeout_latency", 32'(n), 32'(TO));
        wait_done("wb_timeout", 2'd2, 1'b0);
        withhold_at = -1;
        wait_ready("wb_timeout");
        check("wb_timeout_ops_drained", 32'(exp_q.size()), 32'd0);

        // Reset during byte 2: triggers drop at once, init repeats, no stale done.
        push_cmd_ops(16'h3008, 8'h82, NoNack, 0);
        send_cmd(16'h3008, 8'h82);
        n = 0;
        while (!(trig_wr && wb_reg == 3'd3 && wb_wdata == 8'h08) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_op_reached_byte2", 32'(n < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_trig_drop", 32'({trig_wr, trig_rd}), 32'd0);
        check("reset_status_low", 32'({cmd_ready, busy, done, err_code}), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        sr_resp.delete();
        push_init_ops();
        rst_n = 1'b1;
        dones = 0;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            if (done) dones++;
            n++;
        end
        check("reset_reinit_ready", 32'(cmd_ready), 32'd1);
        check("reset_no_stale_done", 32'(dones), 32'd0);
        check("reset_ops_drained", 32'(exp_q.size()), 32'd0);

        // Normal command after all recovery paths.
        rxr_val = 8'h82;
        push_cmd_ops(16'h3008, 8'h82, NoNack, 0);
        send_cmd(16'h3008, 8'h82);
        wait_done("recovered", 2'd0, 1'b1);
        check("recovered_ops_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
